// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand formats, field widths and the FCLASS mask encoding.
package fp_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_info_t;

  localparam int unsigned CLASS_W = 10;

  // One-hot FCLASS result, bit order matches the integer writeback encoding.
  typedef enum logic [CLASS_W-1:0] {
    CLS_NEG_INF  = 10'h001,
    CLS_NEG_NORM = 10'h002,
    CLS_NEG_SUB  = 10'h004,
    CLS_NEG_ZERO = 10'h008,
    CLS_POS_ZERO = 10'h010,
    CLS_POS_SUB  = 10'h020,
    CLS_POS_NORM = 10'h040,
    CLS_POS_INF  = 10'h080,
    CLS_SNAN     = 10'h100,
    CLS_QNAN     = 10'h200
  } classmask_e;

  function automatic int unsigned fp_exp_w(fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned fp_man_w(fp_format_e fmt);
    case (fmt)
      FP16:    return 10;
      FP64:    return 52;
      BF16:    return 7;
      default: return 23;
    endcase
  endfunction

  function automatic fp_info_t fp_info(fp_format_e fmt);
    fp_info_t info;
    info.exp_bits = fp_exp_w(fmt);
    info.man_bits = fp_man_w(fmt);
    return info;
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + fp_exp_w(fmt) + fp_man_w(fmt);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 classifier; done pulses one cycle after a start.
module fp_classify
  import fp_pkg::*;
#(
  parameter fp_format_e FMT = FP32,
  localparam int unsigned W = fp_width(FMT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] operand,
  output classmask_e   cls_c,
  output logic         done
);

  localparam int unsigned EXP_W = fp_exp_w(FMT);
  localparam int unsigned MAN_W = fp_man_w(FMT);

  logic             sign;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;

  assign sign     = operand[W-1];
  assign exponent = operand[W-2 -: EXP_W];
  assign mantissa = operand[MAN_W-1:0];

  // NaN quietness is carried by the mantissa MSB.
  always_comb begin
    cls_c = CLS_POS_ZERO;
    if (&exponent) begin
      if (~|mantissa)               cls_c = sign ? CLS_NEG_INF : CLS_POS_INF;
      else if (mantissa[MAN_W-1])   cls_c = CLS_QNAN;
      else                          cls_c = CLS_SNAN;
    end else if (~|exponent) begin
      if (~|mantissa)               cls_c = sign ? CLS_NEG_ZERO : CLS_POS_ZERO;
      else                          cls_c = sign ? CLS_NEG_SUB : CLS_POS_SUB;
    end else begin
      cls_c = sign ? CLS_NEG_NORM : CLS_POS_NORM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= start;
  end

endmodule

// File: rtl/fp_rr_arbiter.sv
// Pointer-based round-robin arbiter; the pointer moves past the winner on each advance.
module fp_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] grant_c,
  output logic             grant_valid_c
);

  logic [IDX_W-1:0] ptr;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_c       = '0;
    grant_valid_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!grant_valid_c && req[idx]) begin
        grant_valid_c = 1'b1;
        grant_c       = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_c == IDX_W'(N - 1)) ? '0 : grant_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fp_class_arbiter.sv
// Shares one fp_classify between N_REQ requesters and queues {class, id} responses in order.
module fp_class_arbiter
  import fp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned OUT_DEPTH = 2,
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT),
  localparam int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*FP_WIDTH-1:0] req_data_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [CLASS_W-1:0]        resp_class_o,
  output logic [ID_W-1:0]           resp_id_o,
  output logic                      busy_o
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    classmask_e      cls;
    logic [ID_W-1:0] id;
  } fp_class_resp_t;

  logic [ID_W-1:0]     grant;
  logic                grant_valid;
  logic                full;
  logic                accept;
  logic                pop;
  logic [FP_WIDTH-1:0] operand;
  classmask_e          cls;
  logic                classify_done;

  fp_class_resp_t      mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  fp_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk           (clk_i),
    .rst           (rst_i),
    .req           (req_valid_i),
    .advance       (accept),
    .grant_c       (grant),
    .grant_valid_c (grant_valid)
  );

  assign operand = req_data_i[32'(grant)*FP_WIDTH +: FP_WIDTH];

  fp_classify #(.FMT(FP_FORMAT)) u_classify (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (accept),
    .operand (operand),
    .cls_c   (cls),
    .done    (classify_done)
  );

  // A full FIFO blocks accepts even when the head pops this cycle.
  assign full         = (count == CNT_W'(OUT_DEPTH));
  assign accept       = !rst_i && grant_valid && !full;
  assign req_ready_o  = accept ? (N_REQ'(1) << grant) : '0;

  assign resp_valid_o = (count != '0);
  assign busy_o       = resp_valid_o;
  assign pop          = !rst_i && resp_valid_o && resp_ready_i;
  assign resp_class_o = resp_valid_o ? CLASS_W'(mem[rd_ptr].cls) : '0;
  assign resp_id_o    = resp_valid_o ? mem[rd_ptr].id : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= '{cls: cls, id: grant};
  end

  // A completed classification always leaves its response buffered.
  always_ff @(posedge clk_i) begin
    if (!rst_i && classify_done) assert (busy_o);
  end

endmodule

// File: doc/fp_class_arbiter.md
Name: fp_class_arbiter

Overview:
Shares one fp_classify datapath between N_REQ requesters, such as issue lanes or the debug port, using round-robin arbitration. Winning operands are classified and the 10-bit class mask plus requester ID are pushed into a small response FIFO. The consumer drains the FIFO with valid/ready. The block sits between the FP issue stage and the integer writeback of FCLASS results.

Parameters:
FP_FORMAT, FP32, operand format (fp_format_e); FP_WIDTH = fp_width(FP_FORMAT), localparam
N_REQ, 4, number of requesters, 2..8
OUT_DEPTH, 2, response FIFO depth, power of 2, >= 2
ID_W, $clog2(N_REQ), localparam, requester-ID width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  N_REQ  per-requester operand valid
req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
req_data_i  in  N_REQ*FP_WIDTH  operands; requester k occupies bits [k*FP_WIDTH +: FP_WIDTH]
resp_valid_o  out  1  FIFO head valid
resp_ready_i  in  1  consumer accepts head
resp_class_o  out  10  classmask_e of head entry
resp_id_o  out  ID_W  requester index of head entry
busy_o  out  1  FIFO non-empty

Behaviour:
- Reset, applied synchronously when rst_i=1 at the clock edge:
  - rr_ptr=0, FIFO empty, count=0.
  - resp_valid_o=0, resp_class_o=0, resp_id_o=0, busy_o=0, req_ready_o=0.
  - Reset mid-operation discards all buffered responses. No handshake completes in a reset cycle.
- Arbitration (combinational):
  - Search req_valid_i starting at index rr_ptr, ascending, wrapping modulo N_REQ. The first set bit is the grant.
  - req_ready_o[g] = 1 only when a grant g exists and the FIFO is not full (count<OUT_DEPTH). All other bits are 0.
  - req_ready_o may depend combinationally on req_valid_i. req_valid_i must not depend on req_ready_o.
- Accept = (req_valid_i[g] & req_ready_o[g]).
  - On accept, the operand goes through an fp_classify instance (start_i = accept; done_o unused), and {class, g} is written at the FIFO tail on the same edge.
  - rr_ptr <= (g+1) mod N_REQ on accept. rr_ptr is unchanged otherwise.
- Latency: an operand accepted at edge t makes resp_valid_o=1 after edge t if the FIFO was empty. No combinational path from req_* to resp_*.
- Throughput: 1 accept/cycle while resp_ready_i stays high.
- FIFO:
  - Pop when resp_valid_o & resp_ready_i.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
  - Full (count==OUT_DEPTH): no accept, even if a pop happens in the same cycle. This is a decided simplification.
  - Empty: resp_valid_o=0 and resp_class_o/resp_id_o driven 0.
  - Pointers wrap modulo OUT_DEPTH.
- Responses leave strictly in acceptance order.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- Stability: while resp_valid_o=1 and resp_ready_i=0, head outputs hold unchanged.
- Class mask encoding: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN. Exactly one bit is set per response.

Decomposition:
- fp_pkg: fp_format_e, fp_width(), fp_info_t/fp_info(), classmask_e. Add typedef fp_class_resp_t {classmask_e cls; logic [ID_W-1:0] id} only if fp_pkg gains a generic width.
- Keep the struct local otherwise.
- Sub-modules:
  - fp_classify, instantiated once.
  - fp_rr_arbiter: pointer-based round-robin, parameter N, outputs grant index and valid. It is reusable by the other shared FP units.
- The FIFO stays inline.

Test Plan:
- Single requester 0, FP32, resp_ready_i=1. Operands 0xff800000, 0x3f800000, 0x00000001, 0x80000000 on consecutive cycles -> resp_class_o = 0x001, 0x040, 0x020, 0x008, id=0, each one cycle after accept, no bubbles.
- NaNs: 0x7f800001 -> 0x100; 0xffc00000 -> 0x200; 0x7f800000 -> 0x080; 0x00000000 -> 0x010.
- All 4 requesters valid continuously, resp_ready_i=1 -> grant order 0,1,2,3,0,1,… with rr_ptr wrapping 3->0; ids match in resp_id_o.
- resp_ready_i=0 with requesters 1 and 2 valid:
  - 2 accepts, then req_ready_o=0 (full) and head holds id=1.
  - Raise resp_ready_i for one cycle -> pop only, no accept that cycle; next cycle requester 1 or 2 is accepted per rr_ptr.
- Only requester 2 valid with rr_ptr=3 -> grant wraps to 2; rr_ptr becomes 3.
- Assert rst_i with 2 entries buffered and valids high -> next cycle resp_valid_o=0, busy_o=0, req_ready_o=0 during reset; after release the first grant goes to requester 0.
